ej32_muldiv: RTL and testbench
==============================

# ej32_muldiv

Iterative multiply/divide sequencer for the eJ32 ALU. It executes `imul`, `idiv` and `irem` over many cycles so the single-cycle ALU path stays short. The decode/control unit pops value1 (NOS) and value2 (TOS), pulses `start`, stalls while `busy`, and pushes `result` on `done`. Results follow JVM semantics: 32-bit two's complement, quotient truncated toward zero, remainder takes the sign of the dividend.

## Interface
- `DW`, 32: operand/result width; only 32 is supported (`DU`).
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request; accepted only in IDLE with a supported `op`.
- `op`  in  8  `opcode_t`; `imul`, `idiv`, `irem` supported, others ignored.
- `nos`  in  32  value1 (multiplicand/dividend); sampled on accept.
- `tos`  in  32  value2 (multiplier/divisor); sampled on accept.
- `busy`  out  1  high whenever state ≠ IDLE.
- `done`  out  1  one-cycle pulse; `result` is valid in this cycle.
- `result`  out  32  last result; held until the next accepted `start`.
- `div_zero`  out  1  high with `done` when `idiv`/`irem` has divisor 0; held like `result`.

## Operation
- States: IDLE → PREP → ITER → FIX → DONE → IDLE.
- IDLE:
  - On `start` with a supported op, latch `op`, `nos` and `tos`; clear `result` and `div_zero`; go to PREP.
  - `start` with an unsupported op: no state change, no `done`.
- PREP:
  - Divide: record sign_q = sign(nos) XOR sign(tos) and sign_r = sign(nos). Load magnitudes |nos| and |tos| as 32-bit unsigned; |0x80000000| = 0x80000000. Clear the 32-bit remainder accumulator.
  - Divisor == 0: set `div_zero`, `result` = 0, go straight to DONE.
  - Multiply: load raw operands unsigned and clear the 32-bit accumulator. Only the low 32 bits are kept, so no sign handling is needed.
- ITER: exactly 32 cycles, 5-bit counter 0..31, leave on count 31.
  - Divide: one restoring step per cycle, MSB first. Shift {rem, quo} left by 1; if rem ≥ divisor, subtract and set quo[0].
  - Multiply: if multiplier[0], acc += multiplicand; then multiplicand <<= 1 and multiplier >>= 1.
- FIX:
  - `idiv`: `result` = sign_q ? −quo : quo.
  - `irem`: `result` = sign_r ? −rem : rem.
  - `imul`: `result` = acc.
  - All arithmetic is mod 2^32. This yields 0x80000000 / −1 = 0x80000000 and remainder 0 with no special case.
- DONE: `done` = 1 for one cycle, then IDLE.
- `start` while `busy`: ignored, with no queueing. The requester must wait for `done`.
- `nos`, `tos` and `op` changing after accept: no effect.

## Timing
- Accept at edge T (start = 1 in IDLE).
- PREP runs in cycle T+1; ITER in T+2..T+33; FIX in T+34; DONE (`done` = 1) in T+35.
- `busy` = 1 in T+1..T+35 and 0 in T+36. Back-to-back: a new `start` is accepted in cycle T+36.
- Divide by zero: PREP in T+1, DONE in T+2; `busy` is high for 2 cycles.
- Fixed latency: 35 cycles from accept to `done`, independent of operand values.
- Reset values: `busy` = 0, `done` = 0, `result` = 0, `div_zero` = 0, state IDLE, counter 0.
- Reset mid-operation: on the next edge return to IDLE with all outputs at reset values. No `done` is issued for the aborted operation.
- Reset takes priority over `start` on the same edge.

## Structure
- Add `md_state_t` (IDLE, PREP, ITER, FIX, DONE) to `ej32_pkg` so the control unit can observe it. Also add `MD_ITER = 32`.
- Reuse the `opcode_t` enum and the `DU` macro; no local opcode constants.
- One natural sub-module, `ej32_div_step`: combinational single restoring-divide step.
  - Inputs: rem, quo, divisor.
  - Outputs: next rem, next quo.
- The shared accumulator/shift registers are muxed by op inside `ej32_muldiv`.

## Test plan
- `idiv` nos = 7, tos = 2, start at T → `done` in T+35, `result` = 3, `div_zero` = 0. `busy` is high T+1..T+35.
- Signs, one case each:
  - `idiv` −7 / 2 → 0xFFFFFFFD.
  - `irem` −7 % 2 → 0xFFFFFFFF.
  - `irem` 7 % −2 → 1.
  - `idiv` −8 / −2 → 4.
- Overflow edge: `idiv` 0x80000000 / 0xFFFFFFFF → 0x80000000; `irem` on the same operands → 0.
- Divide by zero: `idiv` 5 / 0 → `done` in T+2, `div_zero` = 1, `result` = 0. A following `imul` clears `div_zero` at accept.
- Multiply:
  - `imul` 0x00010000 × 0x00010000 → 0.
  - `imul` −3 × 7 → 0xFFFFFFEB.
  - `imul` 0xFFFFFFFF × 0xFFFFFFFF → 1.
- Control:
  - `start` pulsed at T+5 during busy → ignored; exactly one `done` in T+35.
  - `op` = `iadd` with start → no `busy`, no `done`.
  - `rst` at T+10 → `busy`, `done`, `result` all 0 next cycle; a new `idiv` 9 / 3 then returns 3 after 35 cycles.

Source files
------------

// File: rtl/ej32_pkg.sv
// Shared eJ32 definitions: data width macro, JVM opcode enum and the
// multiply/divide sequencer state enum.
`ifndef DU
`define DU 32
`endif

package ej32_pkg;

  // JVM opcodes seen by the ALU path
  typedef enum logic [7:0] {
    nop   = 8'h00,
    iadd  = 8'h60,
    isub  = 8'h64,
    imul  = 8'h68,
    idiv  = 8'h6c,
    irem  = 8'h70,
    ineg  = 8'h74,
    ishl  = 8'h78,
    ishr  = 8'h7a,
    iushr = 8'h7c,
    iand  = 8'h7e,
    ior   = 8'h80,
    ixor  = 8'h82
  } opcode_t;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PREP = 3'd1,
    ITER = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } md_state_t;

  localparam int MD_ITER = 32;

  // Two's-complement negate when s is set; |0x80000000| stays 0x80000000.
  function automatic logic [`DU-1:0] neg_if(input logic s, input logic [`DU-1:0] v);
    return s ? -v : v;
  endfunction

endpackage

// File: rtl/ej32_div_step.sv
// One restoring-divide step: shift {rem, quo} left, subtract divisor when it
// fits and record the quotient bit.
module ej32_div_step
  import ej32_pkg::*;
#(
  parameter int DW = `DU
) (
  input  logic [DW-1:0] rem,
  input  logic [DW-1:0] quo,
  input  logic [DW-1:0] divisor,
  output logic [DW-1:0] rem_nxt,
  output logic [DW-1:0] quo_nxt
);

  logic [DW:0]   sh;
  logic [DW-1:0] diff;

  // NOTE: every output gets a default before the conditional update, so the
  // block stays purely combinational and no latch is inferred.
  always_comb begin
    sh      = {rem, quo[DW-1]};
    diff    = sh[DW-1:0] - divisor;
    rem_nxt = sh[DW-1:0];
    quo_nxt = {quo[DW-2:0], 1'b0};
    if (sh >= {1'b0, divisor}) begin
      rem_nxt    = diff;
      quo_nxt[0] = 1'b1;
    end
  end

endmodule

// File: rtl/ej32_muldiv.sv
// Iterative imul/idiv/irem sequencer: fixed 35-cycle latency from accept to
// done, JVM truncating-division semantics, early exit on divide by zero.
module ej32_muldiv
  import ej32_pkg::*;
#(
  parameter int DW = `DU
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  opcode_t       op,
  input  logic [DW-1:0] nos,
  input  logic [DW-1:0] tos,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] result,
  output logic          div_zero
);

  md_state_t     st;
  logic [4:0]    cnt;
  opcode_t       op_r;
  logic [DW-1:0] a;       // multiplicand, or dividend shifting into quotient
  logic [DW-1:0] b;       // multiplier, or divisor magnitude
  logic [DW-1:0] acc;     // product accumulator, or partial remainder
  logic          sign_q;
  logic          sign_r;
  logic          op_ok;
  logic [DW-1:0] rem_nxt;
  logic [DW-1:0] quo_nxt;

  assign op_ok = (op == imul) || (op == idiv) || (op == irem);

  ej32_div_step #(.DW(DW)) u_step (
    .rem     (acc),
    .quo     (a),
    .divisor (b),
    .rem_nxt (rem_nxt),
    .quo_nxt (quo_nxt)
  );

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of every other register.
  // Datapath registers are left out of reset: they are always reloaded on
  // accept before being read.
  always_ff @(posedge clk) begin
    if (rst) begin
      st       <= IDLE;
      cnt      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
      div_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (st)
        IDLE: begin
          if (start && op_ok) begin
            op_r     <= op;
            a        <= nos;
            b        <= tos;
            result   <= '0;
            div_zero <= 1'b0;
            busy     <= 1'b1;
            st       <= PREP;
          end
        end
        PREP: begin
          acc <= '0;
          cnt <= '0;
          if (op_r == imul) begin
            st <= ITER;
          end else begin
            sign_q <= a[DW-1] ^ b[DW-1];
            sign_r <= a[DW-1];
            a      <= neg_if(a[DW-1], a);
            b      <= neg_if(b[DW-1], b);
            if (b == '0) begin
              div_zero <= 1'b1;
              done     <= 1'b1;
              st       <= DONE;
            end else begin
              st <= ITER;
            end
          end
        end
        ITER: begin
          if (op_r == imul) begin
            if (b[0]) acc <= acc + a;
            a <= a << 1;
            b <= b >> 1;
          end else begin
            acc <= rem_nxt;
            a   <= quo_nxt;
          end
          cnt <= cnt + 5'd1;
          if (cnt == 5'(MD_ITER - 1)) st <= FIX;
        end
        FIX: begin
          case (op_r)
            idiv:    result <= neg_if(sign_q, a);
            irem:    result <= neg_if(sign_r, acc);
            default: result <= acc;
          endcase
          done <= 1'b1;
          st   <= DONE;
        end
        DONE: begin
          busy <= 1'b0;
          st   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ej32_muldiv.sv
// Self-checking bench for ej32_muldiv: vector table through a result
// scoreboard, plus busy-start, unsupported-op and reset sequences.
module tb_ej32_muldiv;
  import ej32_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  opcode_t     op_i;
  logic [31:0] nos_i;
  logic [31:0] tos_i;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        div_zero;

  ej32_muldiv dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .op       (op_i),
    .nos      (nos_i),
    .tos      (tos_i),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .div_zero (div_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    opcode_t     op;
    logic [31:0] nos;
    logic [31:0] tos;
    logic [31:0] res;
    logic        dz;
    int          lat;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    logic        dz;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Entered and left on a negedge; start is high during the entry cycle, so
  // consecutive calls issue back-to-back requests.
  task automatic run_op(input opcode_t o, input logic [31:0] n, input logic [31:0] t,
                        input logic [31:0] res, input logic dz, input int lat,
                        input bit inject);
    int   seen = 0;
    int   busy_n = 0;
    exp_t e;
    op_i  = o;
    nos_i = n;
    tos_i = t;
    start = 1'b1;
    @(posedge clk);
    sb.push_back('{res: res, dz: dz});
    for (int k = 1; k <= lat + 1; k++) begin
      @(negedge clk);
      if (k == 1) begin
        start = 1'b0;
        op_i  = iadd;
        nos_i = $urandom;
        tos_i = $urandom;
        check("accept_clear_result", result, 32'h0);
        check("accept_clear_dz", {31'b0, div_zero}, 32'h0);
      end
      if (inject && k == 5) begin
        start = 1'b1;
        op_i  = imul;
      end
      if (inject && k == 6) start = 1'b0;
      if (busy) busy_n++;
      if (done) begin
        seen++;
        if (seen == 1) check("done_latency", k, lat);
        if (sb.size() == 0) begin
          check("done_unexpected", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check("result", result, e.res);
          check("div_zero", {31'b0, div_zero}, {31'b0, e.dz});
        end
      end
    end
    if (seen == 0) begin
      $display("FAIL done_timeout actual=none required=done_within_%0d", lat);
      errors++;
      checks++;
      void'(sb.pop_front());
    end
    check("done_count", seen, 1);
    check("busy_cycles", busy_n, lat);
    check("result_held", result, res);
  endtask

  initial begin
    int   dn;
    int   bn;

    vecs.push_back('{idiv, 32'd7,         32'd2,         32'd3,         1'b0, 35});
    vecs.push_back('{idiv, -32'sd7,       32'd2,         32'hFFFFFFFD,  1'b0, 35});
    vecs.push_back('{irem, -32'sd7,       32'd2,         32'hFFFFFFFF,  1'b0, 35});
    vecs.push_back('{irem, 32'd7,         -32'sd2,       32'd1,         1'b0, 35});
    vecs.push_back('{idiv, -32'sd8,       -32'sd2,       32'd4,         1'b0, 35});
    vecs.push_back('{idiv, 32'h80000000,  32'hFFFFFFFF,  32'h80000000,  1'b0, 35});
    vecs.push_back('{irem, 32'h80000000,  32'hFFFFFFFF,  32'd0,         1'b0, 35});
    vecs.push_back('{idiv, 32'd5,         32'd0,         32'd0,         1'b1, 2});
    vecs.push_back('{imul, 32'h00010000,  32'h00010000,  32'd0,         1'b0, 35});
    vecs.push_back('{imul, -32'sd3,       32'd7,         32'hFFFFFFEB,  1'b0, 35});
    vecs.push_back('{imul, 32'hFFFFFFFF,  32'hFFFFFFFF,  32'd1,         1'b0, 35});
    vecs.push_back('{irem, 32'd5,         32'd0,         32'd0,         1'b1, 2});
    vecs.push_back('{idiv, 32'd100,       32'd7,         32'd14,        1'b0, 35});
    vecs.push_back('{irem, 32'd100,       -32'sd7,       32'd2,         1'b0, 35});
    vecs.push_back('{idiv, -32'sd100,     32'd7,         32'hFFFFFFF2,  1'b0, 35});
    vecs.push_back('{irem, -32'sd100,     32'd7,         32'hFFFFFFFE,  1'b0, 35});
    vecs.push_back('{imul, 32'd12345,     32'd6789,      32'h04FED79D,  1'b0, 35});
    vecs.push_back('{idiv, 32'h7FFFFFFF,  32'd1,         32'h7FFFFFFF,  1'b0, 35});
    vecs.push_back('{irem, 32'h80000000,  32'd3,         32'hFFFFFFFE,  1'b0, 35});

    rst   = 1'b1;
    start = 1'b0;
    op_i  = nop;
    nos_i = '0;
    tos_i = '0;
    repeat (2) @(negedge clk);
    check("reset_busy", {31'b0, busy}, 32'h0);
    check("reset_done", {31'b0, done}, 32'h0);
    check("reset_result", result, 32'h0);
    check("reset_div_zero", {31'b0, div_zero}, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    foreach (vecs[i])
      run_op(vecs[i].op, vecs[i].nos, vecs[i].tos, vecs[i].res, vecs[i].dz, vecs[i].lat, 1'b0);

    // A start during busy must be dropped, not queued
    run_op(idiv, 32'd7, 32'd2, 32'd3, 1'b0, 35, 1'b1);

    // Unsupported op: nothing happens, previous result held
    op_i  = iadd;
    nos_i = 32'd1;
    tos_i = 32'd2;
    start = 1'b1;
    dn = 0;
    bn = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (busy) bn++;
      if (done) dn++;
    end
    check("iadd_busy", bn, 0);
    check("iadd_done", dn, 0);
    check("iadd_result_held", result, 32'd3);

    // Reset in the middle of an idiv aborts it with no done
    op_i  = idiv;
    nos_i = 32'd100;
    tos_i = 32'd7;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_busy", {31'b0, busy}, 32'h0);
    check("midrst_done", {31'b0, done}, 32'h0);
    check("midrst_result", result, 32'h0);
    check("midrst_div_zero", {31'b0, div_zero}, 32'h0);
    rst = 1'b0;
    dn = 0;
    bn = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (busy) bn++;
      if (done) dn++;
    end
    check("midrst_no_done", dn, 0);
    check("midrst_no_busy", bn, 0);
    run_op(idiv, 32'd9, 32'd3, 32'd3, 1'b0, 35, 1'b0);

    // Reset wins over start on the same edge
    rst   = 1'b1;
    start = 1'b1;
    op_i  = imul;
    @(negedge clk);
    check("rst_prio_busy", {31'b0, busy}, 32'h0);
    rst   = 1'b0;
    start = 1'b0;
    @(negedge clk);
    check("rst_prio_idle", {31'b0, busy}, 32'h0);
    check("scoreboard_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
